mem_access_stage: RTL and testbench

//  MEM pipeline stage of the MIPS core, directly upstream and downstream of the data memory.

---
 rtl/mem_pkg.sv | 53 +++++
 rtl/load_extender.sv | 42 ++++
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: memory op encoding, exception codes,
// data-memory / peripheral window bounds and op classification helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LW       = 4'd1,
    LH       = 4'd2,
    LHU      = 4'd3,
    LB       = 4'd4,
    LBU      = 4'd5,
    SW       = 4'd6,
    SH       = 4'd7,
    SB       = 4'd8
  } mem_op_e;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;

  localparam logic [31:0] DM_TOP_DEF   = 32'h0000_3000;
  localparam logic [31:0] DEV_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] DEV_TOP_DEF  = 32'h0000_7F20;

  function automatic logic is_load(input mem_op_e op);
    case (op)
      LW, LH, LHU, LB, LBU: is_load = 1'b1;
      default:              is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    case (op)
      SW, SH, SB: is_store = 1'b1;
      default:    is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_word(input mem_op_e op);
    case (op)
      LW, SW:  is_word = 1'b1;
      default: is_word = 1'b0;
    endcase
  endfunction

  function automatic logic is_half(input mem_op_e op);
    case (op)
      LH, LHU, SH: is_half = 1'b1;
      default:     is_half = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
// Pure combinational; shared with the device read path.
module load_extender
  import mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  a,
  input  logic [31:0] word,
  output logic [31:0] rdata
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // lane select and extension
  always_comb begin
    half_s = 16'd0;
    byte_s = 8'd0;
    rdata  = 32'd0;
    if (a[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (a)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
    case (op)
      LW:      rdata = word;
      LH:      rdata = {{16{half_s[15]}}, half_s};
      LHU:     rdata = {16'd0, half_s};
      LB:      rdata = {{24{byte_s[7]}}, byte_s};
      LBU:     rdata = {24'd0, byte_s};
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, DM address/byte-enable/store-lane generation,
// AdEL/AdES detection, load extension and MEM/WB register. Option: ALIGN_EXC_EN.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter logic [31:0] DM_TOP   = DM_TOP_DEF,
  parameter logic [31:0] DEV_BASE = DEV_BASE_DEF,
  parameter logic [31:0] DEV_TOP  = DEV_TOP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        m_stall,
  input  logic        m_flush,
  output logic        dm_memWrite,
  output logic [31:0] dm_memAddr,
  output logic [31:0] dm_memData,
  output logic [3:0]  dm_BE,
  output logic        dm_errored,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_dataOut,
  output logic        m_exc,
  output logic [4:0]  m_exc_code,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic        wb_load,
  output logic [31:0] wb_rdata
);

  logic        m_valid_q, m_valid_d;
  logic [31:0] m_pc_q,    m_pc_d;
  mem_op_e     m_op_q,    m_op_d;
  logic [31:0] m_addr_q,  m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_pc_q,    wb_pc_d;
  logic        wb_load_q,  wb_load_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;

  logic [31:0] eff_addr_s;
  logic [1:0]  a_s;
  logic        active_s, misalign_s, in_dm_s, in_dev_s, fault_s;
  logic [31:0] ext_s;

  // EX/MEM next state: flush beats stall
  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_op_d    = m_op_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    if (m_flush) begin
      m_valid_d = 1'b0;
      m_pc_d    = 32'd0;
      m_op_d    = MEM_NONE;
      m_addr_d  = 32'd0;
      m_wdata_d = 32'd0;
    end else if (m_stall) begin
      m_valid_d = m_valid_q;
    end else begin
      m_valid_d = ex_valid;
      m_pc_d    = ex_pc;
      m_op_d    = mem_op_e'(ex_op);
      m_addr_d  = ex_addr;
      m_wdata_d = ex_wdata;
    end
  end

  // Address alignment and fault classification
  always_comb begin
    eff_addr_s = m_addr_q;
    misalign_s = 1'b0;
`ifdef ALIGN_EXC_EN
    if (is_word(m_op_q)) begin
      misalign_s = (m_addr_q[1:0] != 2'd0);
    end else if (is_half(m_op_q)) begin
      misalign_s = m_addr_q[0];
    end else begin
      misalign_s = 1'b0;
    end
`else
    if (is_word(m_op_q)) begin
      eff_addr_s = {m_addr_q[31:2], 2'b00};
    end else if (is_half(m_op_q)) begin
      eff_addr_s = {m_addr_q[31:1], 1'b0};
    end else begin
      eff_addr_s = m_addr_q;
    end
`endif
    a_s      = eff_addr_s[1:0];
    active_s = m_valid_q && (m_op_q != MEM_NONE);
    in_dm_s  = (eff_addr_s < DM_TOP);
    in_dev_s = (eff_addr_s >= DEV_BASE) && (eff_addr_s < DEV_TOP);
    fault_s  = active_s && (misalign_s || (!in_dm_s && !in_dev_s) ||
                            (in_dev_s && !is_word(m_op_q)));
  end

  // DM-facing outputs and exception report
  always_comb begin
    dm_BE      = 4'b0000;
    dm_memData = 32'd0;
    case (m_op_q)
      SW: begin
        dm_BE      = 4'b1111;
        dm_memData = m_wdata_q;
      end
      SH: begin
        if (a_s[1]) begin
          dm_BE = 4'b1100;
        end else begin
          dm_BE = 4'b0011;
        end
        dm_memData = {2{m_wdata_q[15:0]}};
      end
      SB: begin
        dm_BE      = 4'b0001 << a_s;
        dm_memData = {4{m_wdata_q[7:0]}};
      end
      default: begin
        dm_BE      = 4'b0000;
        dm_memData = 32'd0;
      end
    endcase
    dm_memAddr  = eff_addr_s;
    dm_pc       = m_pc_q;
    // reset gating keeps a half-captured store from reaching DM while reset rises
    dm_memWrite = active_s && is_store(m_op_q) && !fault_s && !reset;
    m_exc       = fault_s;
    if (fault_s) begin
      m_exc_code = is_store(m_op_q) ? EXC_ADES : EXC_ADEL;
    end else begin
      m_exc_code = EXC_NONE;
    end
    dm_errored = fault_s;
  end

  load_extender u_load_extender (
    .op    (m_op_q),
    .a     (a_s),
    .word  (dm_dataOut),
    .rdata (ext_s)
  );

  // MEM/WB next state: bubble on stall, fault or empty MEM
  always_comb begin
    wb_valid_d = 1'b0;
    wb_pc_d    = 32'd0;
    wb_load_d  = 1'b0;
    wb_rdata_d = 32'd0;
    if (m_stall || fault_s || !m_valid_q) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = 1'b1;
      wb_pc_d    = m_pc_q;
      wb_load_d  = is_load(m_op_q);
      wb_rdata_d = is_load(m_op_q) ? ext_s : 32'd0;
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q  <= 1'b0;
      m_pc_q     <= 32'd0;
      m_op_q     <= MEM_NONE;
      m_addr_q   <= 32'd0;
      m_wdata_q  <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= 32'd0;
      wb_load_q  <= 1'b0;
      wb_rdata_q <= 32'd0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_pc_q     <= m_pc_d;
      m_op_q     <= m_op_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_load_q  <= wb_load_d;
      wb_rdata_q <= wb_rdata_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_pc    = wb_pc_q;
  assign wb_load  = wb_load_q;
  assign wb_rdata = wb_rdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small byte-enabled DM model.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        m_stall;
  logic        m_flush;
  logic        dm_memWrite;
  logic [31:0] dm_memAddr;
  logic [31:0] dm_memData;
  logic [3:0]  dm_BE;
  logic        dm_errored;
  logic [31:0] dm_pc;
  logic [31:0] dm_dataOut;
  logic        m_exc;
  logic [4:0]  m_exc_code;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_load;
  logic [31:0] wb_rdata;

  logic [31:0] dm_mem [256];
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_op       (ex_op),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .m_stall     (m_stall),
    .m_flush     (m_flush),
    .dm_memWrite (dm_memWrite),
    .dm_memAddr  (dm_memAddr),
    .dm_memData  (dm_memData),
    .dm_BE       (dm_BE),
    .dm_errored  (dm_errored),
    .dm_pc       (dm_pc),
    .dm_dataOut  (dm_dataOut),
    .m_exc       (m_exc),
    .m_exc_code  (m_exc_code),
    .wb_valid    (wb_valid),
    .wb_pc       (wb_pc),
    .wb_load     (wb_load),
    .wb_rdata    (wb_rdata)
  );

  assign dm_dataOut = dm_mem[dm_memAddr[9:2]];

  // DM model: byte-enabled write on the rising edge
  always @(posedge clk) begin
    if (dm_memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_BE[b]) dm_mem[dm_memAddr[9:2]][b*8 +: 8] <= dm_memData[b*8 +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one instruction from EX; returns #1 after it lands in MEM, with EX idle again.
  task automatic issue(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_addr  = addr;
    ex_wdata = wdata;
    ex_pc    = pc;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    ex_op    = MEM_NONE;
    ex_addr  = 32'd0;
    ex_wdata = 32'd0;
    ex_pc    = 32'd0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dm_mem[i] = 32'd0;
    dm_mem[8'h40] = 32'h8001_7FFF;
    dm_mem[8'hC1] = 32'h1234_5678;
    reset = 1'b1; ex_valid = 1'b0; ex_op = MEM_NONE; ex_addr = 32'd0; ex_wdata = 32'd0;
    ex_pc = 32'd0; m_stall = 1'b0; m_flush = 1'b0;
    step(); step();
    check_eq("rst_memWrite", {31'd0, dm_memWrite}, 32'd0);
    check_eq("rst_memAddr", dm_memAddr, 32'd0);
    check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    #2 reset = 1'b0;
    step();

    // SB to byte 3
    issue(SB, 32'h0000_0013, 32'h0000_00AB, 32'h0000_0100);
    check_eq("sb_BE", {28'd0, dm_BE}, 32'h8);
    check_eq("sb_data", dm_memData, 32'hABAB_ABAB);
    check_eq("sb_write", {31'd0, dm_memWrite}, 32'd1);
    check_eq("sb_exc", {31'd0, m_exc}, 32'd0);
    check_eq("sb_pc", dm_pc, 32'h0000_0100);
    step();
    check_eq("sb_dm", dm_mem[8'h04], 32'hAB00_0000);
    check_eq("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("sb_wb_load", {31'd0, wb_load}, 32'd0);
    check_eq("sb_wb_rdata", wb_rdata, 32'd0);
    check_eq("sb_idle_write", {31'd0, dm_memWrite}, 32'd0);

    // LH / LHU upper half
    issue(LH, 32'h0000_0102, 32'd0, 32'h0000_0104);
    check_eq("lh_BE", {28'd0, dm_BE}, 32'h0);
    check_eq("lh_write", {31'd0, dm_memWrite}, 32'd0);
    step();
    check_eq("lh_rdata", wb_rdata, 32'hFFFF_8001);
    check_eq("lh_wb_load", {31'd0, wb_load}, 32'd1);
    check_eq("lh_wb_pc", wb_pc, 32'h0000_0104);
    issue(LHU, 32'h0000_0102, 32'd0, 32'h0000_0108);
    step();
    check_eq("lhu_rdata", wb_rdata, 32'h0000_8001);
    issue(LB, 32'h0000_0101, 32'd0, 32'h0000_010C);
    step();
    check_eq("lb_rdata", wb_rdata, 32'h0000_007F);
    issue(LBU, 32'h0000_0100, 32'd0, 32'h0000_0110);
    step();
    check_eq("lbu_rdata", wb_rdata, 32'h0000_00FF);

    // SH to upper half
    issue(SH, 32'h0000_0022, 32'h0000_BEEF, 32'h0000_0114);
    check_eq("sh_BE", {28'd0, dm_BE}, 32'hC);
    check_eq("sh_data", dm_memData, 32'hBEEF_BEEF);
    step();
    check_eq("sh_dm", dm_mem[8'h08], 32'hBEEF_0000);

    // misaligned SW
    issue(SW, 32'h0000_0006, 32'hCAFE_F00D, 32'h0000_0118);
`ifdef ALIGN_EXC_EN
    check_eq("sw_mis_exc", {31'd0, m_exc}, 32'd1);
    check_eq("sw_mis_code", {27'd0, m_exc_code}, 32'd5);
    check_eq("sw_mis_err", {31'd0, dm_errored}, 32'd1);
    check_eq("sw_mis_write", {31'd0, dm_memWrite}, 32'd0);
    step();
    check_eq("sw_mis_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("sw_mis_dm", dm_mem[8'h01], 32'd0);
`else
    check_eq("sw_aln_exc", {31'd0, m_exc}, 32'd0);
    check_eq("sw_aln_addr", dm_memAddr, 32'h0000_0004);
    check_eq("sw_aln_BE", {28'd0, dm_BE}, 32'hF);
    check_eq("sw_aln_write", {31'd0, dm_memWrite}, 32'd1);
    step();
    check_eq("sw_aln_dm", dm_mem[8'h01], 32'hCAFE_F00D);
`endif

    // range faults and device window
    issue(LW, 32'h0000_4000, 32'd0, 32'h0000_011C);
    check_eq("lw_oor_exc", {31'd0, m_exc}, 32'd1);
    check_eq("lw_oor_code", {27'd0, m_exc_code}, 32'd4);
    step();
    check_eq("lw_oor_wb_valid", {31'd0, wb_valid}, 32'd0);
    issue(LB, 32'h0000_7F04, 32'd0, 32'h0000_0120);
    check_eq("lb_dev_code", {27'd0, m_exc_code}, 32'd4);
    step();
    issue(SW, 32'h0000_3000, 32'h1, 32'h0000_0124);
    check_eq("sw_oor_code", {27'd0, m_exc_code}, 32'd5);
    check_eq("sw_oor_write", {31'd0, dm_memWrite}, 32'd0);
    step();
    issue(LW, 32'h0000_7F04, 32'd0, 32'h0000_0128);
    check_eq("lw_dev_exc", {31'd0, m_exc}, 32'd0);
    step();
    check_eq("lw_dev_rdata", wb_rdata, 32'h1234_5678);
    check_eq("lw_dev_wb_valid", {31'd0, wb_valid}, 32'd1);

    // stall holds MEM and bubbles WB
    issue(LW, 32'h0000_0100, 32'd0, 32'h0000_012C);
    m_stall = 1'b1;
    ex_valid = 1'b1; ex_op = SW; ex_addr = 32'h0000_0200;
    step();
    check_eq("stall_hold_addr", dm_memAddr, 32'h0000_0100);
    check_eq("stall_wb_valid", {31'd0, wb_valid}, 32'd0);
    m_stall = 1'b0; ex_valid = 1'b0; ex_op = MEM_NONE; ex_addr = 32'd0;
    step();
    check_eq("unstall_rdata", wb_rdata, 32'h8001_7FFF);
    step();

    // flush beats stall
    issue(SW, 32'h0000_0030, 32'h1111_1111, 32'h0000_0130);
    check_eq("fl_write_first", {31'd0, dm_memWrite}, 32'd1);
    m_stall = 1'b1; m_flush = 1'b1;
    step();
    check_eq("fl_write_again", {31'd0, dm_memWrite}, 32'd0);
    check_eq("fl_wb_valid", {31'd0, wb_valid}, 32'd0);
    m_stall = 1'b0; m_flush = 1'b0;
    step();
    check_eq("fl_dm", dm_mem[8'h0C], 32'h1111_1111);

    // reset with a store in MEM
    issue(SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0134);
    check_eq("rs_pre_write", {31'd0, dm_memWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rs_write", {31'd0, dm_memWrite}, 32'd0);
    check_eq("rs_addr", dm_memAddr, 32'd0);
    check_eq("rs_data", dm_memData, 32'd0);
    check_eq("rs_BE", {28'd0, dm_BE}, 32'd0);
    check_eq("rs_pc", dm_pc, 32'd0);
    step();
    reset = 1'b0;
    step(); step();
    check_eq("rs_dm", dm_mem[8'h04], 32'hAB00_0000);
    check_eq("rs_wb_valid", {31'd0, wb_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
